// File: rtl/vid_timing_pkg.sv
// Shared definitions for the video timing generator: region encoding,
// 720p60 default timing constants and the colour-bar RGB table.
package vid_timing_pkg;

  // Region within a line (horizontal) or within a frame (vertical).
  typedef enum logic [1:0] {
    RG_ACT  = 2'd0,
    RG_FP   = 2'd1,
    RG_SYNC = 2'd2,
    RG_BP   = 2'd3
  } region_e;

  // Counter width and the largest total that still fits in it.
  localparam int CNT_W     = 12;
  localparam int MAX_TOTAL = 4096;

  // 1280x720 @ 60 Hz defaults.
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  // Colour bars left to right; index 0 is the leftmost bar.
  localparam int NUM_BARS = 8;
  localparam logic [NUM_BARS-1:0][23:0] BAR_TABLE = {
    24'h000000,  // 7 black
    24'h0000FF,  // 6 blue
    24'hFF0000,  // 5 red
    24'hFF00FF,  // 4 magenta
    24'h00FF00,  // 3 green
    24'h00FFFF,  // 2 cyan
    24'hFFFF00,  // 1 yellow
    24'hFFFFFF   // 0 white
  };

  // Regions are visited in a fixed ring: ACT -> FP -> SYNC -> BP -> ACT.
  function automatic region_e next_region(input region_e r);
    region_e n;
    n = RG_ACT;
    case (r)
      RG_ACT:  n = RG_FP;
      RG_FP:   n = RG_SYNC;
      RG_SYNC: n = RG_BP;
      RG_BP:   n = RG_ACT;
      default: n = RG_ACT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vid_color_bar.sv
// Colour-bar pattern source. Maps the requested column to one of eight
// equal-width bars; columns beyond the last full bar are black. The output
// is registered so it lines up with de_o of the timing generator.
module vid_color_bar
  import vid_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [11:0] x_i,
  output logic [23:0] rgb_o
);

  // Guard against a zero bar width for very narrow test timings.
  localparam int BAR_W = (H_ACTIVE / NUM_BARS > 0) ? (H_ACTIVE / NUM_BARS) : 1;

  logic [31:0] x_ext;
  logic [23:0] bar_d;
  logic [23:0] rgb_q;

  // Pick the bar whose column range contains x_i; default black covers the remainder.
  always_comb begin
    x_ext = {20'd0, x_i};
    bar_d = 24'h000000;
    for (int i = 0; i < NUM_BARS; i++) begin
      if ((x_ext >= 32'(i * BAR_W)) && (x_ext < 32'((i + 1) * BAR_W))) begin
        bar_d = BAR_TABLE[3'(i)];
      end
    end
  end

  // Register the colour only for requested pixels; blanking is forced to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb_q <= 24'h000000;
    end else begin
      rgb_q <= en_i ? bar_d : 24'h000000;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/vid_timing_gen.sv
// Video timing generator for the RGB-to-DVI path.
// Produces de/hsync/vsync and the pixel for the TMDS encoders, plus a
// one-cycle-early pixel request to the frame source.
// Optional build macro: VID_TEST_PATTERN_EN replaces rgb_i with colour bars.
//
// Pipeline: counters/regions -> stage 1 (req, x/y, raw syncs)
//                            -> stage 2 (de, hsync, vsync, rgb, frame_start).
// rgb_i is captured on the edge that closes the data_req_o cycle, so the
// returned pixel appears on rgb_o together with de_o.
//
// Region FSMs (horizontal advances every pixel, vertical on line wrap):
//   state   | meaning
//   RG_ACT  | active pixels / active lines
//   RG_FP   | front porch
//   RG_SYNC | sync pulse
//   RG_BP   | back porch
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic [23:0] rgb_i,
  output logic        data_req_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [23:0] rgb_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL > MAX_TOTAL) || (V_TOTAL > MAX_TOTAL)) begin : g_total_check
    $fatal(1, "vid_timing_gen: H_TOTAL or V_TOTAL exceeds the 12-bit counter range");
  end

  // Last counter value of each region; a region ends when its counter hits this.
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] H_FP_END   = 12'(H_ACTIVE + H_FP - 1);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] V_FP_END   = 12'(V_ACTIVE + V_FP - 1);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  region_e     h_state_q, h_state_d;
  region_e     v_state_q, v_state_d;
  logic [11:0] h_end, v_end;
  logic        h_wrap;
  logic        pix_active;

  // Stage 1
  logic        req_q;
  logic [11:0] x_q, y_q;
  logic        hs_q, vs_q;
  logic        fs1_q;

  // Stage 2
  logic        de_q;
  logic        hsync_q, vsync_q;
  logic        fs_q;

  // Next counter values and region transitions at each region's end boundary.
  always_comb begin
    h_wrap    = (h_cnt_q == H_LAST);
    h_cnt_d   = h_wrap ? 12'd0 : (h_cnt_q + 12'd1);
    v_cnt_d   = v_cnt_q;
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    h_end     = H_LAST;
    v_end     = V_LAST;

    case (h_state_q)
      RG_ACT:  h_end = H_ACT_END;
      RG_FP:   h_end = H_FP_END;
      RG_SYNC: h_end = H_SYNC_END;
      default: h_end = H_LAST;
    endcase

    case (v_state_q)
      RG_ACT:  v_end = V_ACT_END;
      RG_FP:   v_end = V_FP_END;
      RG_SYNC: v_end = V_SYNC_END;
      default: v_end = V_LAST;
    endcase

    if (h_cnt_q == h_end) begin
      h_state_d = next_region(h_state_q);
    end

    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : (v_cnt_q + 12'd1);
      if (v_cnt_q == v_end) begin
        v_state_d = next_region(v_state_q);
      end
    end
  end

  assign pix_active = (h_state_q == RG_ACT) && (v_state_q == RG_ACT);

  // Counter and region state registers; reset restarts the frame at (0,0).
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      h_cnt_q   <= 12'd0;
      v_cnt_q   <= 12'd0;
      h_state_q <= RG_ACT;
      v_state_q <= RG_ACT;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
    end
  end

  // Stage 1: pixel request, requested coordinates (held while idle) and raw syncs.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      req_q <= 1'b0;
      x_q   <= 12'd0;
      y_q   <= 12'd0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      fs1_q <= 1'b0;
    end else begin
      req_q <= pix_active;
      if (pix_active) begin
        x_q <= h_cnt_q;
        y_q <= v_cnt_q;
      end
      hs_q  <= (h_state_q == RG_SYNC) ? HS_POL : ~HS_POL;
      vs_q  <= (v_state_q == RG_SYNC) ? VS_POL : ~VS_POL;
      fs1_q <= pix_active && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    end
  end

  // Stage 2: encoder-facing strobes, one cycle behind the request.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      de_q    <= 1'b0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      fs_q    <= 1'b0;
    end else begin
      de_q    <= req_q;
      hsync_q <= hs_q;
      vsync_q <= vs_q;
      fs_q    <= fs1_q;
    end
  end

`ifdef VID_TEST_PATTERN_EN
  logic [23:0] bar_rgb;
  logic        unused_rgb_i;

  assign unused_rgb_i = ^rgb_i;

  vid_color_bar #(
    .H_ACTIVE (H_ACTIVE)
  ) u_color_bar (
    .clk_i (sys_clk_i),
    .rst_i (rst_i),
    .en_i  (req_q),
    .x_i   (x_q),
    .rgb_o (bar_rgb)
  );

  assign rgb_o = bar_rgb;
`else
  logic [23:0] rgb_q;

  // Stage 2 pixel: capture the returned pixel only for requested slots.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      rgb_q <= 24'h000000;
    end else begin
      rgb_q <= req_q ? rgb_i : 24'h000000;
    end
  end

  assign rgb_o = rgb_q;
`endif

  assign data_req_o    = req_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign de_o          = de_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign frame_start_o = fs_q;

endmodule
